// File: rtl/fifo_status_ctrl_if.sv
// Producer/consumer request and pointer/status bundle
// between the FIFO controller and its neighbours.
interface fifo_status_ctrl_if #(
    parameter int AW = 4
);
    logic          wr;
    logic          rd;
    logic          fifo_we;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr,
        output rd,
        input  fifo_we,
        input  wptr,
        input  rptr,
        input  fifo_full,
        input  fifo_empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr,
        input  rd,
        output fifo_we,
        output wptr,
        output rptr,
        output fifo_full,
        output fifo_empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_status_ctrl.sv
// Pointer and status controller for a 2**AW-deep FIFO array.
// Owns the wrap-bit pointers; everything else derives from them.
module fifo_status_ctrl #(
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_status_ctrl_if.slave bus
);
    localparam logic [AW:0] LP_ONE = (AW+1)'(1);
    localparam logic [AW:0] LP_AF  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] LP_AE  = (AW+1)'(AE_LEVEL);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;
    logic        r_underflow;

    logic        w_full;
    logic        w_empty;
    logic        w_we_ok;
    logic        w_rd_ok;
    logic [AW:0] w_count;

    // Same low bits with differing wrap bits means a full lap apart.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Requests are gated only by their own side's flag; no bypass.
    assign w_we_ok = bus.wr & ~w_full;
    assign w_rd_ok = bus.rd & ~w_empty;
    assign w_count = r_wptr - r_rptr;

    // Advance each pointer on its own accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we_ok) begin
                r_wptr <= r_wptr + LP_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + LP_ONE;
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.fifo_we      = w_we_ok;
    assign bus.wptr         = r_wptr;
    assign bus.rptr         = r_rptr;
    assign bus.fifo_full    = w_full;
    assign bus.fifo_empty   = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= LP_AF);
    assign bus.almost_empty = (w_count <= LP_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Self-checking bench for fifo_status_ctrl: vector table plus
// model-driven scoreboard sequences for fill, drain, wrap, reset.
module tb_fifo_status_ctrl;
    typedef struct packed {
        logic [4:0] wptr;
        logic [4:0] rptr;
        logic [4:0] count;
        logic       we;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } out_t;

    typedef struct {
        logic wr;
        logic rd;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [4:0] m_w;
    logic [4:0] m_r;
    logic       m_ovf;
    logic       m_unf;

    out_t  sb[$];
    string nq[$];
    vec_t  tbl[6];

    fifo_status_ctrl_if #(.AW(4)) bus ();

    fifo_status_ctrl #(
        .AW(4),
        .AF_LEVEL(12),
        .AE_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input int w, input int r, input int c,
                                input bit we, input bit fu, input bit em,
                                input bit af, input bit ae,
                                input bit ov, input bit un);
        out_t o;
        o.wptr  = 5'(w);
        o.rptr  = 5'(r);
        o.count = 5'(c);
        o.we    = we;
        o.full  = fu;
        o.empty = em;
        o.af    = af;
        o.ae    = ae;
        o.ovf   = ov;
        o.unf   = un;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.wptr  = bus.wptr;
        o.rptr  = bus.rptr;
        o.count = bus.count;
        o.we    = bus.fifo_we;
        o.full  = bus.fifo_full;
        o.empty = bus.fifo_empty;
        o.af    = bus.almost_full;
        o.ae    = bus.almost_empty;
        o.ovf   = bus.overflow;
        o.unf   = bus.underflow;
        return o;
    endfunction

    // Reference prediction from the bench's own occupancy model.
    function automatic out_t predict(input logic w, input logic r);
        out_t o;
        logic [4:0] c;
        c = m_w - m_r;
        o.wptr  = m_w;
        o.rptr  = m_r;
        o.count = c;
        o.full  = (c == 5'd16);
        o.empty = (c == 5'd0);
        o.af    = (c >= 5'd12);
        o.ae    = (c <= 5'd4);
        o.we    = w & ~o.full;
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        return o;
    endfunction

    task automatic compare(input string nm, input out_t act,
                           input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input bit use_exp,
                        input out_t exp, input string nm);
        out_t e;
        logic [4:0] c;
        bus.wr = w;
        bus.rd = r;
        e = use_exp ? exp : predict(w, r);
        sb.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got %h want entry",
                     nm, sample());
        end else begin
            compare(nq.pop_front(), sample(), sb.pop_front());
        end
        c = m_w - m_r;
        @(posedge clk);
        if (w && c == 5'd16) m_ovf = 1'b1;
        if (r && c == 5'd0)  m_unf = 1'b1;
        if (w && c != 5'd16) m_w = m_w + 5'd1;
        if (r && c != 5'd0)  m_r = m_r + 5'd1;
        #1;
    endtask

    // Async reset between edges; state must clear without a clock.
    task automatic do_reset(input string nm);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compare(nm, sample(), mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        m_w   = '0;
        m_r   = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        m_w    = '0;
        m_r    = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;

        tbl[0] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[1] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[2] = '{1'b1, 1'b0, mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1)};
        tbl[3] = '{1'b1, 1'b1, mk(1, 0, 1, 1, 0, 0, 0, 1, 0, 1)};
        tbl[4] = '{1'b0, 1'b1, mk(2, 1, 1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[5] = '{1'b0, 1'b0, mk(2, 2, 0, 0, 0, 1, 0, 1, 0, 1)};

        @(posedge clk);
        #1;
        do_reset("reset");

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].rd, 1'b1, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end

        do_reset("reset2");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, $sformatf("fill%0d", i));
        end
        step(1'b1, 1'b0, 1'b1, mk(16, 0, 16, 0, 1, 0, 1, 0, 0, 0),
             "write17");
        step(1'b0, 1'b0, 1'b1, mk(16, 0, 16, 0, 1, 0, 1, 0, 1, 0),
             "overflow");
        step(1'b1, 1'b1, 1'b0, '0, "simul_full");
        step(1'b0, 1'b0, 1'b1, mk(16, 1, 15, 0, 0, 0, 1, 0, 1, 0),
             "after_simul_full");

        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, $sformatf("drain%0d", i));
        end
        step(1'b0, 1'b1, 1'b1, mk(16, 16, 0, 0, 0, 1, 0, 1, 1, 0),
             "read17");
        step(1'b1, 1'b1, 1'b1, mk(16, 16, 0, 1, 0, 1, 0, 1, 1, 1),
             "simul_empty");
        step(1'b0, 1'b0, 1'b1, mk(17, 16, 1, 0, 0, 0, 0, 1, 1, 1),
             "after_simul_empty");

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, $sformatf("to5_%0d", i));
        end
        step(1'b1, 1'b1, 1'b0, '0, "simul_5");
        step(1'b0, 1'b0, 1'b1, mk(22, 17, 5, 0, 0, 0, 0, 0, 1, 1),
             "after_simul_5");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, $sformatf("drain5_%0d", i));
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b0, 1'b0, '0, $sformatf("wrap%0dw%0d", k, i));
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 1'b1, 1'b0, '0, $sformatf("wrap%0dr%0d", k, i));
            end
        end
        step(1'b0, 1'b0, 1'b1, mk(20, 20, 0, 0, 0, 1, 0, 1, 1, 1),
             "wrap_end");

        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, $sformatf("mid%0d", i));
        end
        step(1'b0, 1'b0, 1'b1, mk(29, 20, 9, 0, 0, 0, 0, 0, 1, 1),
             "count9");
        do_reset("mid_reset");
        step(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0),
             "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_status_ctrl.md
# fifo_status_ctrl

Pointer and status controller for the 16 x 8 FIFO storage array. It sits directly upstream of the storage array. It turns raw producer/consumer requests into the write enable and the 5-bit write/read pointers that the array consumes. It also generates the full, empty, threshold, fill-level and error flags. It holds no data storage of its own.

## Interface
Parameters:
- AW, 4, address width; depth = 2**AW = 16; pointers are AW+1 = 5 bits (MSB = wrap bit)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr  in  1  producer write request
- rd  in  1  consumer read request
- fifo_we  out  1  write enable to storage array
- wptr  out  AW+1  write pointer to storage array
- rptr  out  AW+1  read pointer to storage array
- fifo_full  out  1  FIFO holds 16 entries
- fifo_empty  out  1  FIFO holds 0 entries
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  current fill level, 0..16
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Accepted write: we_ok = wr & ~fifo_full. fifo_we = we_ok, combinational. At the rising edge, wptr <= wptr + 1 (mod 32).
- Accepted read: rd_ok = rd & ~fifo_empty. At the rising edge, rptr <= rptr + 1 (mod 32). The array data addressed by the old rptr is the word consumed in that cycle.
- A write while full is dropped even if a read is accepted in the same cycle. A read while empty is dropped even if a write is accepted in the same cycle. No bypass path exists.
- Simultaneous accepted write and read: both pointers advance, count is unchanged, and all flags hold.
- count = wptr - rptr, AW+1-bit modular subtraction, combinational from the registered pointers.
- fifo_empty = (wptr == rptr).
- fifo_full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]).
- almost_full and almost_empty are combinational compares on count.
- overflow is set at an edge where wr & fifo_full. underflow is set at an edge where rd & fifo_empty. Both stay set until rst.
- Pointer wrap: 31 -> 0. The array indexes only the low AW bits. The wrap bit only disambiguates full from empty.

## Timing
- Reset (asynchronous, immediate on rst high): wptr = 0, rptr = 0, overflow = 0, underflow = 0.
- Values derived from the reset state: fifo_empty = 1, fifo_full = 0, count = 0, almost_empty = 1, almost_full = 0, fifo_we = wr & 1.
- The first accepted operation is on the first rising edge after rst deasserts.
- Status latency: flags and count reflect an accepted operation immediately after the edge that performs it. For example, a write accepted in cycle n makes fifo_empty = 0 in cycle n+1.
- fifo_we has zero latency from wr and is valid in the same cycle as the request.
- Reset asserted mid-operation discards all contents: pointers return to 0 and the FIFO reads as empty. The storage array is not cleared, and stale data is unreachable.
- No combinational path from rd to fifo_we, or from wr to rptr.

## Test plan
- Reset check: assert rst with wr = rd = 0 -> wptr = rptr = 0, fifo_empty = 1, count = 0, almost_empty = 1, overflow = underflow = 0.
- Fill to full: 16 consecutive writes -> count steps 1..16; almost_full first asserts after write 12; fifo_full = 1 with wptr = 16 (5'b10000) and rptr = 0. A 17th write -> fifo_we = 0, wptr unchanged, overflow = 1.
- Drain to empty: from full, 16 reads -> rptr = 16, fifo_empty = 1; almost_empty reasserts at count = 4. A 17th read -> rptr unchanged, underflow = 1.
- Wrap-around: 3 rounds of 10 writes then 10 reads -> pointers wrap 31 -> 0 with count correct throughout; fifo_full never asserts; fifo_empty = 1 after each round.
- Simultaneous operations, three cases:
  - At count = 5, wr = rd = 1 -> both pointers +1, count stays 5.
  - At full, wr = rd = 1 -> only rptr advances, count = 15, overflow = 1.
  - At empty, wr = rd = 1 -> only wptr advances, count = 1, underflow = 1.
- Reset mid-operation: at count = 9, pulse rst asynchronously between edges -> pointers are 0 immediately, before the next edge; fifo_empty = 1; sticky flags are cleared.
